bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1: cycles the address and write data are valid before the strobe falls (legal range 1..15).
REQ-002 SHALL have parameter STROBE_CYCLES, default 4: cycles a strobe is held low (legal range 1..15; covers the peripheral's input-sync latency).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1: cycles the address and write data are held after the strobe rises (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 bit: transaction request from requester N, level-held until ackN.
REQ-007 SHALL have ports we0/we1, input, 1 bit: 1 means write, 0 means read, for requester N.
REQ-008 SHALL have ports addr0/addr1, input, 16 bits: target address for requester N.
REQ-009 SHALL have ports wdata0/wdata1, input, 8 bits: write data for requester N.
REQ-010 SHALL have ports ack0/ack1, output, 1 bit: one-cycle completion pulse to requester N.
REQ-011 SHALL have ports rdata0/rdata1, output, 8 bits: last read data returned to requester N.
REQ-012 SHALL have port address_bus, output, 16 bits: external peripheral address.
REQ-013 SHALL have port write_strobe_b, output, 1 bit: active-low external write strobe.
REQ-014 SHALL have port read_strobe_b, output, 1 bit: active-low external read strobe.
REQ-015 SHALL have port data_out, output, 8 bits: write data toward the peripheral bus.
REQ-016 SHALL have port data_oe, output, 1 bit: 1 means the data_out drive is enabled on the shared data bus.
REQ-017 SHALL have port data_in, input, 8 bits: read data sampled from the shared data bus.
REQ-018 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, SETUP, STROBE, HOLD and ACK, and the transitions IDLE->SETUP->STROBE->HOLD->ACK->IDLE.
REQ-020 SHALL arbitrate only in IDLE: one requesting port is granted; when both request, the port not granted last time wins (round-robin); the last-grant register resets to port 1 so that port 0 wins the first tie.
REQ-021 SHALL, on the grant edge, latch addr, we and wdata of the granted port into internal registers; requester-input changes after the grant SHALL be ignored until the next grant.
REQ-022 SHALL drive address_bus and data_out from the latched registers, and hold their last values in IDLE.
REQ-023 SHALL stay SETUP_CYCLES cycles in SETUP, STROBE_CYCLES cycles in STROBE and HOLD_CYCLES cycles in HOLD, counted with one 4-bit down-counter.
REQ-024 SHALL hold write_strobe_b low only in STROBE for a write, and read_strobe_b low only in STROBE for a read; both strobes SHALL never be low together.
REQ-025 SHALL assert data_oe in SETUP, STROBE and HOLD of a write only; data_oe SHALL be 0 in IDLE, in ACK and for the whole of a read.
REQ-026 SHALL, for a read, sample data_in on the clock edge ending the last STROBE cycle and load it into rdataN of the granted port; the other port's rdata and all rdata on writes SHALL be unchanged.
REQ-027 SHALL assert ackN of the granted port for exactly the one ACK cycle; the other ack SHALL stay 0.
REQ-028 SHALL have a latency, from the grant edge to the cycle ack is high, of SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 cycles (7 with defaults).
REQ-029 SHALL support back-to-back transactions: a requester drops or renews req on the edge ending ACK, and the next IDLE cycle arbitrates on the updated req values; the minimum gap between transactions is one IDLE cycle.
REQ-030 SHALL, when a req is low in IDLE, start no transaction; a req that drops mid-transaction SHALL NOT abort the transaction.

Reset
REQ-031 SHALL, on any clock edge with reset=1, including mid-transaction, enter IDLE with no ack issued.
REQ-032 SHALL, under reset, force: write_strobe_b=1, read_strobe_b=1, data_oe=0, ack0=ack1=0, busy=0, address_bus=0, data_out=0, rdata0=rdata1=0, counter=0, last-grant=1.
REQ-033 SHALL give reset priority over every other event, including a grant pending in the same cycle.

Verification
REQ-034 SHALL cover a single write: req0=1, we0=1, addr0=0xA000, wdata0=0x5A -> address_bus=0xA000, data_oe high for 6 cycles, write_strobe_b low for exactly 4 cycles, ack0 pulses 7 cycles after the grant.
REQ-035 SHALL cover a single read: req1=1, we1=0, addr1=0xA001, data_in=0xC3 during STROBE -> read_strobe_b low for 4 cycles, data_oe=0 throughout, rdata1=0xC3 with ack1, rdata0 unchanged.
REQ-036 SHALL cover contention: req0 and req1 rise together and both are renewed after ack -> grant order is 0,1,0,1, one IDLE cycle between transactions, acks never overlap.
REQ-037 SHALL cover a mid-transaction reset: reset=1 in the second STROBE cycle -> next cycle has strobes high, data_oe=0, busy=0, no ack; a following request then completes normally.
REQ-038 SHALL cover input changes after grant: addr0 and we0 change while in SETUP -> the bus keeps the originally latched address and direction.
REQ-039 SHALL cover the minimum configuration: SETUP/STROBE/HOLD=1/1/1 -> ack 4 cycles after the grant, strobe low for exactly 1 cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter driving a strobed peripheral bus.
// Each transaction runs IDLE -> SETUP -> STROBE -> HOLD -> ACK -> IDLE.
module bus_arbiter #(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [7:0]  rdata0,
   output logic [7:0]  rdata1,
   output logic [15:0] address_bus,
   output logic        write_strobe_b,
   output logic        read_strobe_b,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      ACK    = 3'd4
   } state_t;

   // Phase counter is loaded with length-1 and the phase ends when it reads zero.
   localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic        last_grant;
   logic        grant_go;
   logic        grant_port;
   logic        lat_port;
   logic        lat_we;
   logic [15:0] lat_addr;
   logic [7:0]  lat_wdata;
   logic        we_nxt;
   logic        port_nxt;
   logic        sample_rd;
   logic        write_strobe_b_nxt;
   logic        read_strobe_b_nxt;
   logic        data_oe_nxt;
   logic        busy_nxt;
   logic        ack0_nxt;
   logic        ack1_nxt;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      grant_go   = 1'b0;
      grant_port = 1'b0;
      sample_rd  = 1'b0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_go   = 1'b1;
               grant_port = (req0 && req1) ? ~last_grant : req1;
               state_nxt  = SETUP;
               cnt_nxt    = SETUP_LOAD;
            end
         end
         SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = STROBE;
               cnt_nxt   = STROBE_LOAD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               sample_rd = ~lat_we;
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt = ACK;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase

      // Outputs are registered from the next state so the external strobes never glitch.
      we_nxt   = grant_go ? (grant_port ? we1 : we0) : lat_we;
      port_nxt = grant_go ? grant_port : lat_port;

      write_strobe_b_nxt = ~((state_nxt == STROBE) && we_nxt);
      read_strobe_b_nxt  = ~((state_nxt == STROBE) && !we_nxt);
      data_oe_nxt        = we_nxt && ((state_nxt == SETUP) || (state_nxt == STROBE) ||
                                      (state_nxt == HOLD));
      busy_nxt           = (state_nxt != IDLE);
      ack0_nxt           = (state_nxt == ACK) && !port_nxt;
      ack1_nxt           = (state_nxt == ACK) && port_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         last_grant     <= 1'b1;
         lat_port       <= 1'b0;
         lat_we         <= 1'b0;
         lat_addr       <= 16'h0000;
         lat_wdata      <= 8'h00;
         // NOTE: read-data registers are visible outputs, so they are reset like control state.
         rdata0         <= 8'h00;
         rdata1         <= 8'h00;
         write_strobe_b <= 1'b1;
         read_strobe_b  <= 1'b1;
         data_oe        <= 1'b0;
         busy           <= 1'b0;
         ack0           <= 1'b0;
         ack1           <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;

         if (grant_go) begin
            last_grant <= grant_port;
            lat_port   <= grant_port;
            lat_we     <= grant_port ? we1 : we0;
            lat_addr   <= grant_port ? addr1 : addr0;
            lat_wdata  <= grant_port ? wdata1 : wdata0;
         end

         if (sample_rd) begin
            if (lat_port) begin
               rdata1 <= data_in;
            end else begin
               rdata0 <= data_in;
            end
         end

         write_strobe_b <= write_strobe_b_nxt;
         read_strobe_b  <= read_strobe_b_nxt;
         data_oe        <= data_oe_nxt;
         busy           <= busy_nxt;
         ack0           <= ack0_nxt;
         ack1           <= ack1_nxt;
      end
   end

   assign address_bus = lat_addr;
   assign data_out    = lat_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: default 1/4/1 timing instance plus a 1/1/1 instance.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        ack0, ack1;
   logic [7:0]  rdata0, rdata1;
   logic [15:0] address_bus;
   logic        write_strobe_b, read_strobe_b;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  data_in;
   logic        busy;

   logic        s_req0, s_req1, s_we0, s_we1;
   logic [15:0] s_addr0, s_addr1;
   logic [7:0]  s_wdata0, s_wdata1;
   logic        s_ack0, s_ack1;
   logic [7:0]  s_rdata0, s_rdata1;
   logic [15:0] s_address_bus;
   logic        s_write_strobe_b, s_read_strobe_b;
   logic [7:0]  s_data_out;
   logic        s_data_oe;
   logic [7:0]  s_data_in;
   logic        s_busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Observations of the most recent transaction on the default instance.
   int          m_port, m_ack_idx, m_gap, m_oe, m_ws, m_rs;
   bit          m_both, m_ack0, m_ack1;
   logic [15:0] m_addr;
   logic [7:0]  m_dout;

   always #5 clk = ~clk;

   bus_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .address_bus(address_bus), .write_strobe_b(write_strobe_b),
      .read_strobe_b(read_strobe_b), .data_out(data_out), .data_oe(data_oe),
      .data_in(data_in), .busy(busy)
   );

   bus_arbiter #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut_min (
      .clk(clk), .reset(reset),
      .req0(s_req0), .req1(s_req1), .we0(s_we0), .we1(s_we1),
      .addr0(s_addr0), .addr1(s_addr1), .wdata0(s_wdata0), .wdata1(s_wdata1),
      .ack0(s_ack0), .ack1(s_ack1), .rdata0(s_rdata0), .rdata1(s_rdata1),
      .address_bus(s_address_bus), .write_strobe_b(s_write_strobe_b),
      .read_strobe_b(s_read_strobe_b), .data_out(s_data_out), .data_oe(s_data_oe),
      .data_in(s_data_in), .busy(s_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps the default instance until an ack (or 40 cycles) and records what the bus did.
   // Cycle index 1 is the first busy cycle after the grant edge. mode 1 changes port-0
   // inputs in SETUP, mode 2 drops both requests in SETUP.
   task automatic measure(input int mode);
      bit started = 1'b0;
      int idx = 0;
      m_port = -1; m_ack_idx = -1; m_gap = 0; m_oe = 0; m_ws = 0; m_rs = 0;
      m_both = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0; m_addr = 16'h0; m_dout = 8'h0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy) begin
            if (!started) begin
               started = 1'b1;
               if (mode == 1) begin
                  addr0 = 16'hBEEF; we0 = 1'b0; wdata0 = 8'hEE;
               end
               if (mode == 2) begin
                  req0 = 1'b0; req1 = 1'b0;
               end
            end
            idx++;
         end else if (!started) begin
            m_gap++;
         end
         if (data_oe) m_oe++;
         if (!write_strobe_b) begin
            m_ws++; m_addr = address_bus; m_dout = data_out;
         end
         if (!read_strobe_b) begin
            m_rs++; m_addr = address_bus;
         end
         if (!write_strobe_b && !read_strobe_b) m_both = 1'b1;
         data_in = read_strobe_b ? 8'h3C : ((m_rs == 4) ? 8'hC3 : 8'h11);
         if (ack0 || ack1) begin
            m_ack0 = ack0; m_ack1 = ack1; m_port = ack1 ? 1 : 0; m_ack_idx = idx;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0; data_in = 8'h0;
      s_req0 = 1'b0; s_req1 = 1'b0; s_we0 = 1'b0; s_we1 = 1'b0;
      s_addr0 = 16'h0; s_addr1 = 16'h0; s_wdata0 = 8'h0; s_wdata1 = 8'h0; s_data_in = 8'h0;
      tick();
      tick();
      // A request present while reset is high must not start a transaction.
      req0 = 1'b1;
      tick();
      total_cnt++; if ({write_strobe_b, read_strobe_b} !== 2'b11) $display("FAIL reset_strobes got %b exp 11", {write_strobe_b, read_strobe_b}); else pass_cnt++;
      total_cnt++; if ({data_oe, busy, ack0, ack1} !== 4'b0000) $display("FAIL reset_ctrl got %b exp 0000", {data_oe, busy, ack0, ack1}); else pass_cnt++;
      total_cnt++; if (address_bus !== 16'h0000) $display("FAIL reset_addr got %h exp 0000", address_bus); else pass_cnt++;
      total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_dout got %h exp 00", data_out); else pass_cnt++;
      total_cnt++; if ({rdata0, rdata1} !== 16'h0000) $display("FAIL reset_rdata got %h exp 0000", {rdata0, rdata1}); else pass_cnt++;
      total_cnt++; if ({s_write_strobe_b, s_read_strobe_b, s_busy, s_data_oe} !== 4'b1100) $display("FAIL reset_min got %b exp 1100", {s_write_strobe_b, s_read_strobe_b, s_busy, s_data_oe}); else pass_cnt++;
      req0 = 1'b0;
      reset = 1'b0;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy); else pass_cnt++;
   endtask

   task automatic test_single_write();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'hA000; wdata0 = 8'h5A;
      measure(0);
      total_cnt++; if (m_port !== 0) $display("FAIL wr_port got %0d exp 0", m_port); else pass_cnt++;
      total_cnt++; if ({m_ack0, m_ack1} !== 2'b10) $display("FAIL wr_acks got %b exp 10", {m_ack0, m_ack1}); else pass_cnt++;
      total_cnt++; if (m_ack_idx !== 7) $display("FAIL wr_latency got %0d exp 7", m_ack_idx); else pass_cnt++;
      total_cnt++; if (m_oe !== 6) $display("FAIL wr_oe_cycles got %0d exp 6", m_oe); else pass_cnt++;
      total_cnt++; if (m_ws !== 4) $display("FAIL wr_strobe_cycles got %0d exp 4", m_ws); else pass_cnt++;
      total_cnt++; if (m_rs !== 0) $display("FAIL wr_rd_strobe got %0d exp 0", m_rs); else pass_cnt++;
      total_cnt++; if (m_addr !== 16'hA000) $display("FAIL wr_addr got %h exp A000", m_addr); else pass_cnt++;
      total_cnt++; if (m_dout !== 8'h5A) $display("FAIL wr_data got %h exp 5A", m_dout); else pass_cnt++;
      req0 = 1'b0;
      tick();
      total_cnt++; if ({ack0, busy, data_oe} !== 3'b000) $display("FAIL wr_after_ack got %b exp 000", {ack0, busy, data_oe}); else pass_cnt++;
      total_cnt++; if (address_bus !== 16'hA000) $display("FAIL wr_idle_hold got %h exp A000", address_bus); else pass_cnt++;
      total_cnt++; if (rdata0 !== 8'h00) $display("FAIL wr_rdata0 got %h exp 00", rdata0); else pass_cnt++;
   endtask

   task automatic test_single_read();
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'hA001; wdata1 = 8'h99;
      measure(0);
      total_cnt++; if (m_port !== 1) $display("FAIL rd_port got %0d exp 1", m_port); else pass_cnt++;
      total_cnt++; if (m_ack_idx !== 7) $display("FAIL rd_latency got %0d exp 7", m_ack_idx); else pass_cnt++;
      total_cnt++; if (m_rs !== 4) $display("FAIL rd_strobe_cycles got %0d exp 4", m_rs); else pass_cnt++;
      total_cnt++; if ({m_ws, m_oe} !== {32'd0, 32'd0}) $display("FAIL rd_no_write ws %0d oe %0d exp 0 0", m_ws, m_oe); else pass_cnt++;
      total_cnt++; if (m_addr !== 16'hA001) $display("FAIL rd_addr got %h exp A001", m_addr); else pass_cnt++;
      total_cnt++; if (rdata1 !== 8'hC3) $display("FAIL rd_rdata1 got %h exp C3", rdata1); else pass_cnt++;
      total_cnt++; if (rdata0 !== 8'h00) $display("FAIL rd_rdata0 got %h exp 00", rdata0); else pass_cnt++;
      req1 = 1'b0;
      tick();
      total_cnt++; if ({ack1, busy} !== 2'b00) $display("FAIL rd_after_ack got %b exp 00", {ack1, busy}); else pass_cnt++;
   endtask

   task automatic test_contention();
      int exp_port [4] = '{0, 1, 0, 1};
      int exp_gap  [4] = '{0, 1, 1, 1};
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h1000; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h2000;
      for (int t = 0; t < 4; t++) begin
         measure(0);
         total_cnt++; if (m_port !== exp_port[t]) $display("FAIL rr_port[%0d] got %0d exp %0d", t, m_port, exp_port[t]); else pass_cnt++;
         total_cnt++; if (m_gap !== exp_gap[t]) $display("FAIL rr_gap[%0d] got %0d exp %0d", t, m_gap, exp_gap[t]); else pass_cnt++;
         total_cnt++; if ((m_ack0 && m_ack1) !== 1'b0) $display("FAIL rr_ack_overlap[%0d] got 1 exp 0", t); else pass_cnt++;
         total_cnt++; if (m_both !== 1'b0) $display("FAIL rr_both_strobes[%0d] got 1 exp 0", t); else pass_cnt++;
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("FAIL rr_final_idle got %b exp 0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h5000;
      measure(0);
      total_cnt++; if (rdata0 !== 8'hC3) $display("FAIL b2b_rdata0 got %h exp C3", rdata0); else pass_cnt++;
      addr0 = 16'h5001;
      measure(0);
      total_cnt++; if (m_gap !== 1) $display("FAIL b2b_gap got %0d exp 1", m_gap); else pass_cnt++;
      total_cnt++; if (m_addr !== 16'h5001) $display("FAIL b2b_addr got %h exp 5001", m_addr); else pass_cnt++;
      total_cnt++; if (m_ack_idx !== 7) $display("FAIL b2b_latency got %0d exp 7", m_ack_idx); else pass_cnt++;
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_req_drop();
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h6000; wdata1 = 8'h66;
      measure(2);
      total_cnt++; if (m_port !== 1) $display("FAIL drop_port got %0d exp 1", m_port); else pass_cnt++;
      total_cnt++; if (m_ws !== 4) $display("FAIL drop_strobe got %0d exp 4", m_ws); else pass_cnt++;
      tick();
      tick();
      tick();
      total_cnt++; if (busy !== 1'b0) $display("FAIL no_req_idle got %b exp 0", busy); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h3000; wdata0 = 8'h33;
      tick();
      tick();
      tick();
      total_cnt++; if (write_strobe_b !== 1'b0) $display("FAIL mr_in_strobe got %b exp 0", write_strobe_b); else pass_cnt++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total_cnt++; if ({write_strobe_b, read_strobe_b, data_oe, busy} !== 4'b1100) $display("FAIL mr_ctrl got %b exp 1100", {write_strobe_b, read_strobe_b, data_oe, busy}); else pass_cnt++;
      total_cnt++; if ({ack0, ack1} !== 2'b00) $display("FAIL mr_ack got %b exp 00", {ack0, ack1}); else pass_cnt++;
      total_cnt++; if (rdata1 !== 8'h00) $display("FAIL mr_rdata1 got %h exp 00", rdata1); else pass_cnt++;
      measure(0);
      total_cnt++; if (m_port !== 0) $display("FAIL mr_after_port got %0d exp 0", m_port); else pass_cnt++;
      total_cnt++; if (m_ack_idx !== 7) $display("FAIL mr_after_latency got %0d exp 7", m_ack_idx); else pass_cnt++;
      total_cnt++; if (m_gap !== 0) $display("FAIL mr_after_gap got %0d exp 0", m_gap); else pass_cnt++;
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_input_change();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h4444; wdata0 = 8'h44;
      measure(1);
      total_cnt++; if (m_addr !== 16'h4444) $display("FAIL chg_addr got %h exp 4444", m_addr); else pass_cnt++;
      total_cnt++; if (m_dout !== 8'h44) $display("FAIL chg_data got %h exp 44", m_dout); else pass_cnt++;
      total_cnt++; if ({m_ws, m_rs} !== {32'd4, 32'd0}) $display("FAIL chg_dir ws %0d rs %0d exp 4 0", m_ws, m_rs); else pass_cnt++;
      req0 = 1'b0; we0 = 1'b0;
      tick();
   endtask

   task automatic test_min_config();
      int idx, ws, rs, oe, ack_idx;
      s_req0 = 1'b1; s_we0 = 1'b1; s_addr0 = 16'h0ABC; s_wdata0 = 8'h77;
      idx = 0; ws = 0; oe = 0; ack_idx = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_busy) idx++;
         if (!s_write_strobe_b) ws++;
         if (s_data_oe) oe++;
         if (s_ack0) begin
            ack_idx = idx;
            break;
         end
      end
      s_req0 = 1'b0;
      total_cnt++; if (ack_idx !== 4) $display("FAIL min_wr_latency got %0d exp 4", ack_idx); else pass_cnt++;
      total_cnt++; if (ws !== 1) $display("FAIL min_wr_strobe got %0d exp 1", ws); else pass_cnt++;
      total_cnt++; if (oe !== 3) $display("FAIL min_wr_oe got %0d exp 3", oe); else pass_cnt++;
      tick();
      s_req1 = 1'b1; s_we1 = 1'b0; s_addr1 = 16'h0DEF;
      idx = 0; rs = 0; ack_idx = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_busy) idx++;
         if (!s_read_strobe_b) rs++;
         s_data_in = s_read_strobe_b ? 8'h3C : 8'hC3;
         if (s_ack1) begin
            ack_idx = idx;
            break;
         end
      end
      s_req1 = 1'b0;
      total_cnt++; if (ack_idx !== 4) $display("FAIL min_rd_latency got %0d exp 4", ack_idx); else pass_cnt++;
      total_cnt++; if (rs !== 1) $display("FAIL min_rd_strobe got %0d exp 1", rs); else pass_cnt++;
      total_cnt++; if (s_rdata1 !== 8'hC3) $display("FAIL min_rd_rdata1 got %h exp C3", s_rdata1); else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_back_to_back();
      test_req_drop();
      test_mid_reset();
      test_input_change();
      test_min_config();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
